// File: rtl/surf_cout_pkg.sv
// Shared types and helpers for the SURF COUT/DOUT lane alignment controllers.
// Holds the controller state encoding, the tap geometry and the rotation matcher.
package surf_cout_pkg;

  localparam int TAP_W     = 5;
  localparam int TAP_COUNT = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ISR_RST,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_NEXT,
    ST_EVAL,
    ST_CLOAD,
    ST_CSETTLE,
    ST_SLIP_CHECK,
    ST_SLIP,
    ST_SLIP_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  // True when nib equals pat under any of the four nibble rotations.
  function automatic logic rot_match(input logic [3:0] nib, input logic [3:0] pat);
    return (nib == pat) ||
           (nib == {pat[2:0], pat[3]}) ||
           (nib == {pat[1:0], pat[3:2]}) ||
           (nib == {pat[0], pat[3:1]});
  endfunction

endpackage

// File: rtl/surf_eye_tracker.sv
// Tracks the current run of good taps and the widest run seen during a sweep.
// Ties keep the earlier run, so the first eye of a given width wins.
module surf_eye_tracker
  import surf_cout_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             strobe,
  input  logic             good,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] run_start,
  output logic [5:0]       run_len,
  output logic [TAP_W-1:0] best_start,
  output logic [5:0]       best_len
);

  logic [5:0]       run_next;
  logic [TAP_W-1:0] start_next;

  assign run_next   = run_len + 6'd1;
  assign start_next = (run_len == 6'd0) ? tap : run_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (strobe) begin
      if (good) begin
        run_start <= start_next;
        run_len   <= run_next;
        if (run_next > best_len) begin
          best_start <= start_next;
          best_len   <= run_next;
        end
      end else begin
        run_len <= '0;
      end
    end
  end

endmodule

// File: rtl/surf_cout_align_ctrl.sv
// COUT lane training: sweep IDELAY taps, centre on the widest stable eye,
// then bitslip until the SURF training nibble lands word-aligned.
module surf_cout_align_ctrl
  import surf_cout_pkg::*;
#(
  parameter logic [3:0] TRAIN_PATTERN = 4'b1000,
  parameter int         CHECK_CYCLES  = 64,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MIN_EYE       = 4
) (
  input  logic             sysclk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       cout_i,
  output logic             iserdes_rst_o,
  output logic             iserdes_bitslip_o,
  output logic [TAP_W-1:0] idelay_value_o,
  output logic             idelay_load_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [TAP_W-1:0] eye_start_o,
  output logic [5:0]       eye_width_o
);

  state_t           state, state_next;
  logic [7:0]       cnt;
  logic [TAP_W-1:0] tap;
  logic [3:0]       ref_q;
  logic             tap_good;
  logic [2:0]       slips;
  logic             done_q, fail_q;
  logic             check_bad;
  logic             eye_ok;
  logic [5:0]       centre_sum;
  logic [TAP_W-1:0] run_start, best_start;
  logic [5:0]       run_len, best_len;

  // The first CHECK cycle qualifies the reference; later cycles must repeat it.
  assign check_bad  = (cnt == 8'd0) ? !rot_match(cout_i, TRAIN_PATTERN) : (cout_i != ref_q);
  assign eye_ok     = (best_len >= 6'(MIN_EYE));
  assign centre_sum = {1'b0, best_start} + (best_len >> 1);

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (start_i) state_next = ST_ISR_RST;
      ST_ISR_RST:    if (cnt == 8'd3) state_next = ST_LOAD;
      ST_LOAD:       state_next = ST_SETTLE;
      ST_SETTLE:     if (cnt == 8'(SETTLE_CYCLES - 1)) state_next = ST_CHECK;
      ST_CHECK:      if (check_bad || cnt == 8'(CHECK_CYCLES - 1)) state_next = ST_NEXT;
      ST_NEXT:       state_next = (tap == TAP_W'(TAP_COUNT - 1)) ? ST_EVAL : ST_LOAD;
      ST_EVAL:       state_next = eye_ok ? ST_CLOAD : ST_FAIL;
      ST_CLOAD:      state_next = ST_CSETTLE;
      ST_CSETTLE:    if (cnt == 8'(SETTLE_CYCLES - 1)) state_next = ST_SLIP_CHECK;
      ST_SLIP_CHECK: begin
        if (cout_i == TRAIN_PATTERN) state_next = ST_DONE;
        else if (slips == 3'd4)      state_next = ST_FAIL;
        else                         state_next = ST_SLIP;
      end
      ST_SLIP:       state_next = ST_SLIP_WAIT;
      ST_SLIP_WAIT:  if (cnt == 8'(SLIP_WAIT - 1)) state_next = ST_SLIP_CHECK;
      ST_DONE:       state_next = ST_IDLE;
      ST_FAIL:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    iserdes_rst_o     = (state == ST_ISR_RST);
    iserdes_bitslip_o = (state == ST_SLIP);
    idelay_load_o     = (state == ST_LOAD) || (state == ST_CLOAD);
    busy_o            = (state != ST_IDLE);
    idelay_value_o    = tap;
    done_o            = done_q;
    fail_o            = fail_q;
    eye_start_o       = best_start;
    eye_width_o       = best_len;
  end

  // cnt restarts on every state change, so each state times itself from zero.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt      <= '0;
      tap      <= '0;
      ref_q    <= '0;
      tap_good <= 1'b0;
      slips    <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      cnt <= (state_next != state) ? 8'd0 : cnt + 8'd1;
      case (state)
        ST_IDLE: if (start_i) begin
          tap    <= '0;
          done_q <= 1'b0;
          fail_q <= 1'b0;
        end
        ST_CHECK: begin
          if (cnt == 8'd0) ref_q <= cout_i;
          tap_good <= !check_bad;
        end
        ST_NEXT: if (tap != TAP_W'(TAP_COUNT - 1)) tap <= tap + TAP_W'(1);
        ST_EVAL: begin
          slips <= '0;
          if (eye_ok) tap <= centre_sum[TAP_W-1:0];
        end
        ST_SLIP: slips <= slips + 3'd1;
        ST_DONE: done_q <= 1'b1;
        ST_FAIL: fail_q <= 1'b1;
        default: ;
      endcase
    end
  end

  surf_eye_tracker u_eye (
    .clk        (sysclk_i),
    .rst_n      (rst_n_i),
    .clear      ((state == ST_IDLE) && start_i),
    .strobe     (state == ST_NEXT),
    .good       (tap_good),
    .tap        (tap),
    .run_start  (run_start),
    .run_len    (run_len),
    .best_start (best_start),
    .best_len   (best_len)
  );

endmodule
